layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
- Autonomous generator of the forward and backward layer-number token streams that drive the layer splitters, activation stack and backpropagator.
- Replaces hand-driven layer pulses with a parametrised sequencer that:
  - supports a runtime layer count and a runtime sample count;
  - has a training/inference mode;
  - paces samples on a weight-update completion pulse.
- Sits upstream of the forward splitter (fw tokens) and the backward splitter (bw tokens).

Parameters:
LAYER_ADDR_WIDTH, 2, width of layer tokens and of the top-layer config
LAYER_MAX, 2, highest legal layer index; larger runtime requests clamp to this
SAMPLE_COUNT_WIDTH, 10, width of sample count and sample index

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  single-cycle run request, sampled in IDLE only
train  input  1  1 = forward+backward per sample, 0 = forward only; latched on start
top_layer  input  LAYER_ADDR_WIDTH  highest forward layer index; latched on start, clamped to LAYER_MAX
sample_count  input  SAMPLE_COUNT_WIDTH  samples to process; latched on start
update_done  input  1  pulse from backpropagator: weight update for current sample complete
fw_layer  output  LAYER_ADDR_WIDTH  forward layer token
fw_layer_valid  output  1  forward token valid
fw_layer_ready  input  1  forward consumer ready
bw_layer  output  LAYER_ADDR_WIDTH  backward layer token
bw_layer_valid  output  1  backward token valid
bw_layer_ready  input  1  backward consumer ready
sample_index  output  SAMPLE_COUNT_WIDTH  index of sample in flight (0-based)
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when run completes

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 (fw_layer, bw_layer, valids, sample_index, busy, done).
- States: IDLE, FW, BW, WAIT.
- All outputs are registered.
- Handshake rules:
  - A transfer occurs when valid & ready.
  - valid holds and the token is stable until the transfer.
  - valid never depends combinationally on ready.
- IDLE:
  - On start=1, latch train, top=min(top_layer, LAYER_MAX) and sample_count; sample_index=0.
  - If sample_count=0: done=1 next cycle, stay IDLE, no tokens issued.
  - Otherwise go to FW next cycle with fw_layer=0, fw_layer_valid=1, busy=1.
- FW, on each fw transfer:
  - If fw_layer<top: fw_layer+1 valid on the next cycle (throughput one token/cycle).
  - If fw_layer==top and train=1 and top>0: go to BW with bw_layer=top-1 and bw_layer_valid=1 next cycle; fw_layer_valid=0.
  - If fw_layer==top and (train=0 or top=0): the sample ends. Next sample begins immediately (fw_layer=0 valid next cycle, sample_index+1), or, if this was the last sample, go to IDLE with done=1 for one cycle.
- BW, on each bw transfer:
  - If bw_layer>0: bw_layer-1 valid next cycle.
  - If bw_layer==0: go to WAIT; bw_layer_valid=0.
- WAIT:
  - On update_done=1, end the sample using the same rule as FW end-of-sample.
  - update_done in any other state is ignored (not counted, not stored).
- start while busy is ignored; config inputs are only sampled when start is accepted.
- The fw and bw streams are never valid in the same cycle.
- sample_index wraps are impossible: the run ends at sample_count-1.
- update_done and final bw transfer in the same cycle: the update_done is ignored (state not yet WAIT).
- Reset asserted mid-run: immediate return to IDLE, valids drop asynchronously, no done pulse.
- Token sequence per sample (train, top=2): fw 0,1,2 then bw 1,0.

Test Plan:
- train=1, top_layer=2, sample_count=1, ready always 1:
  - fw tokens 0,1,2 on 3 consecutive cycles, then bw 1,0.
  - Then WAIT until update_done.
  - Pulse update_done → done=1 one cycle, busy=0.
- train=1, top_layer=2, sample_count=3, update_done 5 cycles after each entry to WAIT → three identical token sequences, sample_index 0,1,2, single done at end.
- train=0, top_layer=3 with LAYER_MAX=2, sample_count=2 → fw 0,1,2,0,1,2 back-to-back (clamped), no bw tokens, done after last transfer.
- Backpressure:
  - Hold fw_layer_ready=0 for 4 cycles with fw_layer=1 valid → token and valid stable throughout, no skip.
  - Same check for bw_layer_ready with bw_layer=1.
- sample_count=0 → done next cycle, no valids.
- start pulses while busy → ignored; update_done while in FW → ignored.
- Async reset mid-BW → all outputs 0 immediately.
- Fresh start afterwards restarts at fw 0, sample_index 0.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Forward/backward layer-token streams between the sequencer and the layer splitters.
// master drives tokens and valids; slave returns the readies.
interface layer_sequencer_if #(
    parameter int unsigned LAYER_ADDR_WIDTH = 2
);
    logic [LAYER_ADDR_WIDTH-1:0] fw_layer;
    logic                        fw_layer_valid;
    logic                        fw_layer_ready;
    logic [LAYER_ADDR_WIDTH-1:0] bw_layer;
    logic                        bw_layer_valid;
    logic                        bw_layer_ready;

    modport master (
        output fw_layer,
        output fw_layer_valid,
        input  fw_layer_ready,
        output bw_layer,
        output bw_layer_valid,
        input  bw_layer_ready
    );

    modport slave (
        input  fw_layer,
        input  fw_layer_valid,
        output fw_layer_ready,
        input  bw_layer,
        input  bw_layer_valid,
        output bw_layer_ready
    );
endinterface

// File: rtl/layer_sequencer.sv
// Autonomous layer-token sequencer: forward (and optionally backward) token streams per sample,
// paced by the weight-update completion pulse in training mode.
module layer_sequencer #(
    parameter int unsigned LAYER_ADDR_WIDTH   = 2,
    parameter int unsigned LAYER_MAX          = 2,
    parameter int unsigned SAMPLE_COUNT_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          train,
    input  logic [LAYER_ADDR_WIDTH-1:0]   top_layer,
    input  logic [SAMPLE_COUNT_WIDTH-1:0] sample_count,
    input  logic                          update_done,
    layer_sequencer_if.master             tok,
    output logic [SAMPLE_COUNT_WIDTH-1:0] sample_index,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FW,
        S_BW,
        S_WAIT
    } state_t;

    localparam logic [LAYER_ADDR_WIDTH-1:0]   LAYER_MAX_W = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [LAYER_ADDR_WIDTH-1:0]   LAYER_ONE   = LAYER_ADDR_WIDTH'(1);
    localparam logic [SAMPLE_COUNT_WIDTH-1:0] SAMPLE_ONE  = SAMPLE_COUNT_WIDTH'(1);

    state_t                        state, state_n;
    logic                          train_q, train_n;
    logic [LAYER_ADDR_WIDTH-1:0]   top_q, top_n;
    logic [SAMPLE_COUNT_WIDTH-1:0] count_q, count_n;
    logic [LAYER_ADDR_WIDTH-1:0]   fw_layer_q, fw_layer_n;
    logic                          fw_valid_q, fw_valid_n;
    logic [LAYER_ADDR_WIDTH-1:0]   bw_layer_q, bw_layer_n;
    logic                          bw_valid_q, bw_valid_n;
    logic [SAMPLE_COUNT_WIDTH-1:0] index_n;
    logic                          busy_n;
    logic                          done_n;

    logic                          fw_fire;
    logic                          bw_fire;
    logic                          end_sample;
    logic                          last_sample;
    logic [LAYER_ADDR_WIDTH-1:0]   top_clamped;

    assign tok.fw_layer       = fw_layer_q;
    assign tok.fw_layer_valid = fw_valid_q;
    assign tok.bw_layer       = bw_layer_q;
    assign tok.bw_layer_valid = bw_valid_q;

    assign fw_fire     = fw_valid_q && tok.fw_layer_ready;
    assign bw_fire     = bw_valid_q && tok.bw_layer_ready;
    assign last_sample = (sample_index == (count_q - SAMPLE_ONE));
    assign top_clamped = (top_layer > LAYER_MAX_W) ? LAYER_MAX_W : top_layer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            train_q      <= 1'b0;
            top_q        <= '0;
            count_q      <= '0;
            fw_layer_q   <= '0;
            fw_valid_q   <= 1'b0;
            bw_layer_q   <= '0;
            bw_valid_q   <= 1'b0;
            sample_index <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            train_q      <= train_n;
            top_q        <= top_n;
            count_q      <= count_n;
            fw_layer_q   <= fw_layer_n;
            fw_valid_q   <= fw_valid_n;
            bw_layer_q   <= bw_layer_n;
            bw_valid_q   <= bw_valid_n;
            sample_index <= index_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        train_n    = train_q;
        top_n      = top_q;
        count_n    = count_q;
        fw_layer_n = fw_layer_q;
        fw_valid_n = fw_valid_q;
        bw_layer_n = bw_layer_q;
        bw_valid_n = bw_valid_q;
        index_n    = sample_index;
        busy_n     = busy;
        done_n     = 1'b0;
        end_sample = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    train_n = train;
                    top_n   = top_clamped;
                    count_n = sample_count;
                    index_n = '0;
                    if (sample_count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n    = S_FW;
                        fw_layer_n = '0;
                        fw_valid_n = 1'b1;
                        busy_n     = 1'b1;
                    end
                end
            end
            S_FW: begin
                if (fw_fire) begin
                    if (fw_layer_q < top_q) begin
                        fw_layer_n = fw_layer_q + LAYER_ONE;
                    end else if (train_q && (top_q != '0)) begin
                        state_n    = S_BW;
                        fw_valid_n = 1'b0;
                        bw_layer_n = top_q - LAYER_ONE;
                        bw_valid_n = 1'b1;
                    end else begin
                        end_sample = 1'b1;
                    end
                end
            end
            S_BW: begin
                if (bw_fire) begin
                    if (bw_layer_q != '0) begin
                        bw_layer_n = bw_layer_q - LAYER_ONE;
                    end else begin
                        state_n    = S_WAIT;
                        bw_valid_n = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (update_done) begin
                    end_sample = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Shared end-of-sample step: reached from a final fw transfer or from update_done in WAIT.
        if (end_sample) begin
            if (last_sample) begin
                state_n    = S_IDLE;
                fw_valid_n = 1'b0;
                fw_layer_n = '0;
                bw_layer_n = '0;
                busy_n     = 1'b0;
                done_n     = 1'b1;
            end else begin
                state_n    = S_FW;
                fw_layer_n = '0;
                fw_valid_n = 1'b1;
                index_n    = sample_index + SAMPLE_ONE;
            end
        end
    end

    a_streams_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(fw_valid_q && bw_valid_q));

    a_fw_hold: assert property (@(posedge clk) disable iff (!rst)
        (fw_valid_q && !tok.fw_layer_ready) |=> (fw_valid_q && $stable(fw_layer_q)));

    a_bw_hold: assert property (@(posedge clk) disable iff (!rst)
        (bw_valid_q && !tok.bw_layer_ready) |=> (bw_valid_q && $stable(bw_layer_q)));

    a_busy_state: assert property (@(posedge clk) disable iff (!rst)
        busy == (state != S_IDLE));

endmodule
